// File: rtl/ring_wb_net.sv
// Slotted writeback ring: each stop owns one rotating slot and an injection FIFO.
// Defining RING_FLUSH_EN adds the flush input that clears every slot and FIFO.
module ring_wb_net #(
  parameter int XLEN          = 32,
  parameter int PHYS_REG_SIZE = 256,
  parameter int ROB_ENTRY     = 256,
  parameter int RF_QUEUE      = 8,
  parameter int NUM_STOPS     = 5,
  localparam int PW = $clog2(PHYS_REG_SIZE),
  localparam int RW = $clog2(ROB_ENTRY)
) (
  input  logic                      clk,
  input  logic                      rst_n,
`ifdef RING_FLUSH_EN
  input  logic                      flush,
`endif
  input  logic [NUM_STOPS-1:0]      in_valid,
  output logic [NUM_STOPS-1:0]      in_ready,
  input  logic [NUM_STOPS*PW-1:0]   in_reg,
  input  logic [NUM_STOPS*XLEN-1:0] in_val,
  input  logic [NUM_STOPS*RW-1:0]   in_rob,
  output logic [NUM_STOPS-1:0]      out_valid,
  output logic [NUM_STOPS*PW-1:0]   out_reg,
  output logic [NUM_STOPS*XLEN-1:0] out_val,
  output logic                      out_rob_valid,
  output logic [PW-1:0]             out_rob_update_reg,
  output logic [XLEN-1:0]           out_rob_update_val,
  output logic [RW-1:0]             out_rob_rob_entry
);

  localparam int SW = $clog2(NUM_STOPS);
  localparam int AW = $clog2(RF_QUEUE);
  localparam logic [SW-1:0] LAST_PHASE = SW'(NUM_STOPS - 1);

  typedef struct packed {
    logic [PW-1:0]   r;
    logic [XLEN-1:0] val;
    logic [RW-1:0]   rob;
  } data_t;

  typedef struct packed {
    logic          v;
    logic [SW-1:0] src;
    data_t         d;
  } slot_t;

  logic [SW-1:0]  phase_q, phase_d;
  logic           rdy_q;
  logic           inj;
  logic           flush_w;
  slot_t          slot_q [NUM_STOPS];
  slot_t          slot_d [NUM_STOPS];
  data_t          mem_q  [NUM_STOPS][RF_QUEUE];
  data_t          in_data[NUM_STOPS];
  data_t          head   [NUM_STOPS];
  logic [AW:0]    wp_q   [NUM_STOPS];
  logic [AW:0]    rp_q   [NUM_STOPS];
  logic [NUM_STOPS-1:0] empty, full, accept, push, pop, bypass;

`ifdef RING_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // Every stop injects on the same edge, so the ring never has slot conflicts.
  assign inj     = (phase_q == LAST_PHASE);
  assign phase_d = inj ? '0 : phase_q + SW'(1);

  always_comb begin
    empty  = '0;
    full   = '0;
    accept = '0;
    push   = '0;
    pop    = '0;
    bypass = '0;
    for (int j = 0; j < NUM_STOPS; j++) begin
      in_data[j] = {in_reg[j*PW +: PW], in_val[j*XLEN +: XLEN], in_rob[j*RW +: RW]};
      head[j]    = mem_q[j][rp_q[j][AW-1:0]];
      empty[j]   = (wp_q[j] == rp_q[j]);
      full[j]    = (wp_q[j] == {~rp_q[j][AW], rp_q[j][AW-1:0]});
    end
    in_ready = {NUM_STOPS{rdy_q}} & ~full;
    for (int j = 0; j < NUM_STOPS; j++) begin
      accept[j] = in_valid[j] & in_ready[j] & ~flush_w;
      pop[j]    = inj & ~empty[j] & ~flush_w;
      bypass[j] = inj & empty[j] & accept[j];
      push[j]   = accept[j] & ~bypass[j];
    end
  end

  always_comb begin
    for (int j = 0; j < NUM_STOPS; j++) begin
      slot_d[j] = '0;
      if (inj) begin
        if (!empty[j]) begin
          slot_d[j].v   = 1'b1;
          slot_d[j].src = SW'(j);
          slot_d[j].d   = head[j];
        end else if (accept[j]) begin
          slot_d[j].v   = 1'b1;
          slot_d[j].src = SW'(j);
          slot_d[j].d   = in_data[j];
        end
      end else begin
        slot_d[j] = slot_q[(j + NUM_STOPS - 1) % NUM_STOPS];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int j = 0; j < NUM_STOPS; j++) begin
      if (push[j]) mem_q[j][wp_q[j][AW-1:0]] <= in_data[j];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
      rdy_q   <= 1'b0;
      for (int j = 0; j < NUM_STOPS; j++) begin
        slot_q[j] <= '0;
        wp_q[j]   <= '0;
        rp_q[j]   <= '0;
      end
    end else begin
      // Phase keeps running through a flush.
      phase_q <= phase_d;
      rdy_q   <= 1'b1;
      for (int j = 0; j < NUM_STOPS; j++) begin
        if (flush_w) begin
          slot_q[j] <= '0;
          wp_q[j]   <= '0;
          rp_q[j]   <= '0;
        end else begin
          slot_q[j] <= slot_d[j];
          if (push[j]) wp_q[j] <= wp_q[j] + (AW+1)'(1);
          if (pop[j])  rp_q[j] <= rp_q[j] + (AW+1)'(1);
        end
      end
    end
  end

  always_comb begin
    out_valid = '0;
    out_reg   = '0;
    out_val   = '0;
    for (int i = 0; i < NUM_STOPS; i++) begin
      out_valid[i]            = slot_q[i].v;
      out_reg[i*PW +: PW]     = slot_q[i].d.r;
      out_val[i*XLEN +: XLEN] = slot_q[i].d.val;
    end
    out_rob_valid      = slot_q[0].v;
    out_rob_update_reg = slot_q[0].d.r;
    out_rob_update_val = slot_q[0].d.val;
    out_rob_rob_entry  = slot_q[0].d.rob;
  end

endmodule

// File: tb/tb_ring_wb_net.sv
// Bench for ring_wb_net: queue-level delivery model plus directed literal checks.
`timescale 1ns/1ps
module tb_ring_wb_net;
  localparam int NS = 5, PW = 8, XW = 32, RW = 8, RFQ = 8;

  typedef struct packed {
    logic [PW-1:0] r;
    logic [XW-1:0] v;
    logic [RW-1:0] rob;
  } pkt_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic [NS-1:0]    in_valid = '0;
  logic [NS*PW-1:0] in_reg = '0;
  logic [NS*XW-1:0] in_val = '0;
  logic [NS*RW-1:0] in_rob = '0;
  wire  [NS-1:0]    in_ready, out_valid;
  wire  [NS*PW-1:0] out_reg;
  wire  [NS*XW-1:0] out_val;
  wire              out_rob_valid;
  wire  [PW-1:0]    out_rob_update_reg;
  wire  [XW-1:0]    out_rob_update_val;
  wire  [RW-1:0]    out_rob_rob_entry;

  ring_wb_net dut (
    .clk(clk), .rst_n(rst_n),
`ifdef RING_FLUSH_EN
    .flush(flush),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_val(in_val), .in_rob(in_rob),
    .out_valid(out_valid), .out_reg(out_reg), .out_val(out_val),
    .out_rob_valid(out_rob_valid), .out_rob_update_reg(out_rob_update_reg),
    .out_rob_update_val(out_rob_update_val), .out_rob_rob_entry(out_rob_rob_entry)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: per-stop pending queues; each injected packet is seen at stop
  // (src+age) mod N in the age-th cycle after its injection edge.
  int   mphase = 0, mcyc = 0;
  bit   mready = 1'b0;
  pkt_t mq [NS][$];
  bit   iv [NS];
  pkt_t ip [NS];
  int   it [NS];

  always @(posedge clk or negedge rst_n) begin : model
    bit   acc;
    pkt_t inp;
    if (!rst_n) begin
      mphase = 0; mcyc = 0; mready = 1'b0;
      for (int j = 0; j < NS; j++) begin mq[j].delete(); iv[j] = 1'b0; end
    end else begin
      for (int j = 0; j < NS; j++) begin
        inp.r   = in_reg[j*PW +: PW];
        inp.v   = in_val[j*XW +: XW];
        inp.rob = in_rob[j*RW +: RW];
        acc = in_valid[j] && mready && (mq[j].size() < RFQ) && !flush;
        if (flush) begin
          mq[j].delete(); iv[j] = 1'b0;
        end else if (mphase == NS-1) begin
          if (mq[j].size() > 0) begin
            ip[j] = mq[j].pop_front(); iv[j] = 1'b1; it[j] = mcyc;
            if (acc) mq[j].push_back(inp);
          end else if (acc) begin
            ip[j] = inp; iv[j] = 1'b1; it[j] = mcyc;
          end else iv[j] = 1'b0;
        end else if (acc) mq[j].push_back(inp);
      end
      mphase = (mphase + 1) % NS;
      mcyc++;
      mready = 1'b1;
    end
  end

  always @(negedge clk) begin : compare
    bit   ev;
    pkt_t ep;
    int   age;
    for (int s = 0; s < NS; s++) begin
      ev = 1'b0; ep = '0;
      for (int j = 0; j < NS; j++) begin
        if (iv[j]) begin
          age = mcyc - it[j] - 1;
          if (age >= 0 && age < NS && (j + age) % NS == s) begin ev = 1'b1; ep = ip[j]; end
        end
      end
      chk($sformatf("out_valid[%0d]", s), 64'(out_valid[s]), 64'(ev));
      chk($sformatf("in_ready[%0d]", s), 64'(in_ready[s]), 64'(mready && mq[s].size() < RFQ));
      if (ev) begin
        chk($sformatf("out_reg[%0d]", s), 64'(out_reg[s*PW +: PW]), 64'(ep.r));
        chk($sformatf("out_val[%0d]", s), 64'(out_val[s*XW +: XW]), 64'(ep.v));
      end else if (!rst_n) begin
        chk($sformatf("rst_reg[%0d]", s), 64'(out_reg[s*PW +: PW]), 64'(0));
        chk($sformatf("rst_val[%0d]", s), 64'(out_val[s*XW +: XW]), 64'(0));
      end
      if (s == 0) begin
        chk("rob_valid", 64'(out_rob_valid), 64'(ev));
        if (ev) begin
          chk("rob_reg", 64'(out_rob_update_reg), 64'(ep.r));
          chk("rob_val", 64'(out_rob_update_val), 64'(ep.v));
          chk("rob_entry", 64'(out_rob_rob_entry), 64'(ep.rob));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_phase(input int p);
    int g = 0;
    while (mphase != p && g < 20) begin tick(); g++; end
    chk("wait_phase_bound", 64'(g < 20), 64'(1));
  endtask

  task automatic offer(input int j, input logic [PW-1:0] r, input logic [XW-1:0] v,
                       input logic [RW-1:0] rob);
    in_valid[j] = 1'b1;
    in_reg[j*PW +: PW] = r;
    in_val[j*XW +: XW] = v;
    in_rob[j*RW +: RW] = rob;
  endtask

  task automatic clear_in();
    in_valid = '0; in_reg = '0; in_val = '0; in_rob = '0;
  endtask

  task automatic drain(input int n);
    repeat (n) tick();
  endtask

  logic [NS-1:0] exp_seq [6];
  int k, guard, first_block;
  bit rdy;

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #3;
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_in_ready", 64'(in_ready), 64'(0));
    chk("reset_rob_valid", 64'(out_rob_valid), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("ready_after_release", 64'(in_ready), 64'(5'b11111));

    // Single packet from stop 4 injected at phase 4.
    wait_phase(4);
    offer(4, 8'd55, 32'h1234_5678, 8'd19);
    tick(); clear_in();
    exp_seq[0] = 5'b10000; exp_seq[1] = 5'b00001; exp_seq[2] = 5'b00010;
    exp_seq[3] = 5'b00100; exp_seq[4] = 5'b01000; exp_seq[5] = 5'b00000;
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("single_t+%0d", c+1), 64'(out_valid), 64'(exp_seq[c]));
      if (c == 1) begin
        chk("single_rob_valid", 64'(out_rob_valid), 64'(1));
        chk("single_rob_entry", 64'(out_rob_rob_entry), 64'(19));
        chk("single_rob_val", 64'(out_rob_update_val), 64'(32'h1234_5678));
      end
      tick();
    end
    drain(NS);

    // Concurrent inject from stops 0 and 4.
    wait_phase(4);
    offer(0, 8'd12, 32'h8765_4321, 8'd91);
    offer(4, 8'd55, 32'h1234_5678, 8'd19);
    tick(); clear_in();
    chk("conc_valid", 64'(out_valid), 64'(5'b10001));
    chk("conc_rob_entry", 64'(out_rob_rob_entry), 64'(91));
    chk("conc_reg0", 64'(out_reg[0 +: PW]), 64'(12));
    chk("conc_reg4", 64'(out_reg[4*PW +: PW]), 64'(55));
    drain(NS + 2);

    // Queue wait: pushed at phase 1, injected at the next phase-4 edge.
    wait_phase(1);
    offer(2, 8'd77, 32'hA5A5_0001, 8'd3);
    tick(); clear_in();
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("qwait_t+%0d", c), 64'(out_valid), 64'(0));
      tick();
    end
    chk("qwait_t+4", 64'(out_valid), 64'(5'b00100));
    chk("qwait_reg", 64'(out_reg[2*PW +: PW]), 64'(77));
    drain(NS + 2);

    // Backpressure: 10 back-to-back offers from stop 1 starting at phase 0.
    wait_phase(0);
    k = 0; guard = 0; first_block = -1;
    while (k < 10 && guard < 100) begin
      offer(1, PW'(100 + k), 32'hB000_0000 + XW'(k), RW'(40 + k));
      rdy = in_ready[1];
      if (!rdy && first_block < 0) first_block = k;
      tick();
      if (rdy) k++;
      guard++;
    end
    clear_in();
    chk("bp_bound", 64'(guard < 100), 64'(1));
    chk("bp_accepted_before_full", 64'(first_block), 64'(9));
    drain(60);

`ifdef RING_FLUSH_EN
    wait_phase(4);
    offer(0, 8'd1, 32'h1, 8'd1); offer(1, 8'd2, 32'h2, 8'd2);
    tick(); clear_in();
    offer(2, 8'd3, 32'h3, 8'd3); offer(3, 8'd4, 32'h4, 8'd4); offer(4, 8'd5, 32'h5, 8'd5);
    tick(); clear_in();
    flush = 1'b1;
    offer(0, 8'd9, 32'h9, 8'd9);
    tick(); flush = 1'b0; clear_in();
    chk("flush_valid", 64'(out_valid), 64'(0));
    chk("flush_rob_valid", 64'(out_rob_valid), 64'(0));
    chk("flush_ready", 64'(in_ready), 64'(5'b11111));
    wait_phase(4);
    offer(3, 8'd66, 32'hC0DE_0003, 8'd33);
    tick(); clear_in();
    chk("post_flush_valid", 64'(out_valid), 64'(5'b01000));
    drain(NS + 2);
`endif

    // Reset mid-broadcast with all five stops in flight.
    wait_phase(4);
    for (int j = 0; j < NS; j++) offer(j, PW'(200 + j), 32'hD000_0000 + XW'(j), RW'(60 + j));
    tick(); clear_in();
    tick();
    rst_n = 1'b0;
    #2;
    chk("midrst_valid", 64'(out_valid), 64'(0));
    chk("midrst_rob_valid", 64'(out_rob_valid), 64'(0));
    chk("midrst_ready", 64'(in_ready), 64'(0));
    chk("midrst_reg", 64'(out_reg), 64'(0));
    chk("midrst_val_any", 64'(|out_val), 64'(0));
    chk("midrst_rob_entry", 64'(out_rob_rob_entry), 64'(0));
    #1 rst_n = 1'b1;
    tick(); tick(); tick();
    offer(3, 8'd88, 32'hE000_0003, 8'd7);
    tick(); clear_in();
    chk("postrst_wait", 64'(out_valid), 64'(0));
    tick();
    chk("postrst_phase_inject", 64'(out_valid), 64'(5'b01000));
    chk("postrst_reg", 64'(out_reg[3*PW +: PW]), 64'(88));
    drain(NS + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
